// File: rtl/mem_stage_pkg.sv
// Shared opcode constants, FSM state type and opcode helpers for the memory stage.
package mem_stage_pkg;

    localparam logic [4:0] OP_NOP   = 5'd0;
    localparam logic [4:0] OP_LOAD  = 5'd14;
    localparam logic [4:0] OP_STORE = 5'd15;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_e;

    function automatic logic writes_reg(input logic [4:0] op);
        return (op != OP_NOP) && (op != OP_STORE);
    endfunction

    function automatic logic is_mem_op(input logic [4:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/mem_stage_ctrl.sv
// Memory pipeline stage: retires ALU ops in one cycle, runs loads/stores over a
// req/ack port with a timeout, stalls upstream while busy, drives MEM/WB fields.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RD_W    = 9,
    parameter int BR_W    = 7,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [4:0]        OpCode,
    input  logic [RD_W-1:0]   RdOut,
    input  logic [BR_W-1:0]   BranchResult,
    input  logic [DATA_W-1:0] AluResult,
    input  logic [DATA_W-1:0] store_data,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_we,
    output logic [RD_W-1:0]   wb_rd,
    output logic [BR_W-1:0]   wb_branch,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_err,
    output state_e            dbg_state_o
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [RD_W-1:0]     rd_q, rd_d;
    logic [BR_W-1:0]     br_q, br_d;
    logic [4:0]          op_q, op_d;

    logic                wb_valid_q, wb_valid_d;
    logic                wb_reg_we_q, wb_reg_we_d;
    logic [RD_W-1:0]     wb_rd_q, wb_rd_d;
    logic [BR_W-1:0]     wb_branch_q, wb_branch_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic                mem_err_q, mem_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            rd_q        <= '0;
            br_q        <= '0;
            op_q        <= OP_NOP;
            wb_valid_q  <= 1'b0;
            wb_reg_we_q <= 1'b0;
            wb_rd_q     <= '0;
            wb_branch_q <= '0;
            wb_data_q   <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            rd_q        <= rd_d;
            br_q        <= br_d;
            op_q        <= op_d;
            wb_valid_q  <= wb_valid_d;
            wb_reg_we_q <= wb_reg_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_branch_q <= wb_branch_d;
            wb_data_q   <= wb_data_d;
            mem_err_q   <= mem_err_d;
        end
    end

    // wb_* hold their last values between retires; only wb_valid and mem_err pulse.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        rd_d        = rd_q;
        br_d        = br_q;
        op_d        = op_q;
        wb_valid_d  = 1'b0;
        wb_reg_we_d = wb_reg_we_q;
        wb_rd_d     = wb_rd_q;
        wb_branch_d = wb_branch_q;
        wb_data_d   = wb_data_q;
        mem_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_mem_op(OpCode)) begin
                        state_d = WAIT_ACK;
                        cnt_d   = '0;
                        addr_d  = AluResult;
                        wdata_d = store_data;
                        we_d    = (OpCode == OP_STORE);
                        rd_d    = RdOut;
                        br_d    = BranchResult;
                        op_d    = OpCode;
                    end else begin
                        wb_valid_d  = 1'b1;
                        wb_reg_we_d = writes_reg(OpCode);
                        wb_rd_d     = RdOut;
                        wb_branch_d = BranchResult;
                        wb_data_d   = AluResult;
                    end
                end
            end
            WAIT_ACK: begin
                // An ack in the final timeout cycle still completes the access.
                if (mem_ack) begin
                    state_d     = IDLE;
                    wb_valid_d  = 1'b1;
                    wb_reg_we_d = writes_reg(op_q);
                    wb_rd_d     = rd_q;
                    wb_branch_d = br_q;
                    wb_data_d   = (op_q == OP_LOAD) ? mem_rdata : '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    wb_valid_d  = 1'b1;
                    wb_reg_we_d = 1'b0;
                    wb_rd_d     = rd_q;
                    wb_branch_d = br_q;
                    wb_data_d   = '0;
                    mem_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request stays asserted with stable addr/we/wdata from entry to WAIT_ACK until ack or timeout.
    always_comb begin
        stall       = (state_q == WAIT_ACK);
        mem_req     = (state_q == WAIT_ACK);
        mem_we      = (state_q == WAIT_ACK) && we_q;
        mem_addr    = (state_q == WAIT_ACK) ? addr_q  : '0;
        mem_wdata   = (state_q == WAIT_ACK) ? wdata_q : '0;
        wb_valid    = wb_valid_q;
        wb_reg_we   = wb_reg_we_q;
        wb_rd       = wb_rd_q;
        wb_branch   = wb_branch_q;
        wb_data     = wb_data_q;
        mem_err     = mem_err_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized self-checking bench for mem_stage_ctrl against a transaction-level
// model of retire results and memory-port behaviour.
module tb_mem_stage_ctrl;
    import mem_stage_pkg::*;

    localparam int DATA_W  = 32;
    localparam int RD_W    = 9;
    localparam int BR_W    = 7;
    localparam int TIMEOUT = 16;
    localparam int ENT_W   = 3 + RD_W + BR_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [4:0]        OpCode;
    logic [RD_W-1:0]   RdOut;
    logic [BR_W-1:0]   BranchResult;
    logic [DATA_W-1:0] AluResult;
    logic [DATA_W-1:0] store_data;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              wb_valid;
    logic              wb_reg_we;
    logic [RD_W-1:0]   wb_rd;
    logic [BR_W-1:0]   wb_branch;
    logic [DATA_W-1:0] wb_data;
    logic              mem_err;
    state_e            dbg_state;

    mem_stage_ctrl #(
        .DATA_W(DATA_W), .RD_W(RD_W), .BR_W(BR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .OpCode(OpCode), .RdOut(RdOut),
        .BranchResult(BranchResult), .AluResult(AluResult), .store_data(store_data),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_reg_we(wb_reg_we), .wb_rd(wb_rd), .wb_branch(wb_branch),
        .wb_data(wb_data), .mem_err(mem_err), .dbg_state_o(dbg_state)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Scoreboard: entry = {data_checked, err, reg_we, rd, br, data}
    int n_checks = 0;
    int n_pass   = 0;
    logic [ENT_W-1:0]  exp_q[$];
    logic [DATA_W-1:0] last_data;
    logic              last_data_known;
    logic [RD_W-1:0]   last_rd;
    logic [BR_W-1:0]   last_br;
    logic              last_we;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [ENT_W-1:0] model_retire(
        input logic [4:0] op, input logic [RD_W-1:0] rd, input logic [BR_W-1:0] br,
        input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] rdata, input logic timed_out);
        logic              dchk;
        logic              we;
        logic [DATA_W-1:0] data;
        dchk = 1'b1;
        if (timed_out) begin
            we = 1'b0; data = '0;
        end else if (op == OP_LOAD) begin
            we = 1'b1; data = rdata;
        end else if (op == OP_STORE) begin
            we = 1'b0; data = '0;
        end else if (op == OP_NOP) begin
            we = 1'b0; data = '0; dchk = 1'b0;
        end else begin
            we = 1'b1; data = alu;
        end
        return {dchk, timed_out, we, rd, br, data};
    endfunction

    task automatic check_retire(input string tag);
        logic [ENT_W-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 64'(1), 64'(0));
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_wb_valid"},  64'(wb_valid), 64'(1));
        check({tag, "_mem_err"},   64'(mem_err), 64'(e[ENT_W-2]));
        check({tag, "_wb_reg_we"}, 64'(wb_reg_we), 64'(e[ENT_W-3]));
        check({tag, "_wb_rd"},     64'(wb_rd), 64'(e[DATA_W+BR_W +: RD_W]));
        check({tag, "_wb_branch"}, 64'(wb_branch), 64'(e[DATA_W +: BR_W]));
        if (e[ENT_W-1]) check({tag, "_wb_data"}, 64'(wb_data), 64'(e[DATA_W-1:0]));
        check({tag, "_stall_after"},   64'(stall), 64'(0));
        check({tag, "_mem_req_after"}, 64'(mem_req), 64'(0));
        last_data_known = e[ENT_W-1];
        last_data       = e[DATA_W-1:0];
        last_we         = e[ENT_W-3];
        last_rd         = e[DATA_W+BR_W +: RD_W];
        last_br         = e[DATA_W +: BR_W];
    endtask

    // Driver: caller is between a negedge and the next posedge with the DUT idle.
    // ack_delay = wait cycle (1-based) in which mem_ack rises; > TIMEOUT means never.
    task automatic issue(input string tag, input logic [4:0] op, input logic [RD_W-1:0] rd,
                         input logic [BR_W-1:0] br, input logic [DATA_W-1:0] alu,
                         input logic [DATA_W-1:0] sd, input int ack_delay,
                         input logic [DATA_W-1:0] rdata);
        logic mem_op;
        logic timed_out;
        int   n_req;
        mem_op    = (op == OP_LOAD) || (op == OP_STORE);
        timed_out = mem_op && (ack_delay > TIMEOUT);
        n_req     = (ack_delay > TIMEOUT) ? TIMEOUT : ack_delay;
        in_valid = 1'b1; OpCode = op; RdOut = rd; BranchResult = br;
        AluResult = alu; store_data = sd;
        mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        check({tag, "_accept_stall"}, 64'(stall), 64'(0));
        exp_q.push_back(model_retire(op, rd, br, alu, rdata, timed_out));
        @(posedge clk); #1;
        in_valid = 1'b0; OpCode = 5'($urandom); RdOut = RD_W'($urandom);
        BranchResult = BR_W'($urandom); AluResult = $urandom; store_data = $urandom;
        mem_ack = 1'b0;
        if (mem_op) begin
            for (int i = 1; i <= n_req; i++) begin
                mem_ack   = (i == ack_delay);
                mem_rdata = (i == ack_delay) ? rdata : $urandom;
                @(negedge clk);
                check({tag, "_mem_req"},   64'(mem_req), 64'(1));
                check({tag, "_mem_we"},    64'(mem_we), 64'(op == OP_STORE));
                check({tag, "_mem_addr"},  64'(mem_addr), 64'(alu));
                if (op == OP_STORE) check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(sd));
                check({tag, "_stall"},     64'(stall), 64'(1));
                check({tag, "_wb_valid_busy"}, 64'(wb_valid), 64'(0));
                check({tag, "_dbg_state"}, 64'(dbg_state), 64'(WAIT_ACK));
                @(posedge clk); #1;
                mem_ack = 1'b0;
            end
        end
        @(negedge clk);
        check_retire(tag);
    endtask

    task automatic idle_cycle(input string tag);
        in_valid = 1'b0;
        mem_ack  = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_wb_valid"},  64'(wb_valid), 64'(0));
        check({tag, "_mem_err"},   64'(mem_err), 64'(0));
        check({tag, "_wb_rd"},     64'(wb_rd), 64'(last_rd));
        check({tag, "_wb_branch"}, 64'(wb_branch), 64'(last_br));
        check({tag, "_wb_reg_we"}, 64'(wb_reg_we), 64'(last_we));
        if (last_data_known) check({tag, "_wb_data"}, 64'(wb_data), 64'(last_data));
        check({tag, "_mem_req"},   64'(mem_req), 64'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"},     64'(stall), 64'(0));
        check({tag, "_mem_req"},   64'(mem_req), 64'(0));
        check({tag, "_mem_we"},    64'(mem_we), 64'(0));
        check({tag, "_mem_addr"},  64'(mem_addr), 64'(0));
        check({tag, "_wb_valid"},  64'(wb_valid), 64'(0));
        check({tag, "_wb_reg_we"}, 64'(wb_reg_we), 64'(0));
        check({tag, "_wb_data"},   64'(wb_data), 64'(0));
        check({tag, "_wb_rd"},     64'(wb_rd), 64'(0));
        check({tag, "_mem_err"},   64'(mem_err), 64'(0));
        last_data = '0; last_data_known = 1'b1; last_rd = '0; last_br = '0; last_we = 1'b0;
    endtask

    initial begin
        logic [4:0] op;
        int         kind;
        rst = 1'b1; in_valid = 1'b0; OpCode = '0; RdOut = '0; BranchResult = '0;
        AluResult = '0; store_data = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        issue("alu_basic", 5'd3, 9'd8, 7'd1, 32'd2, 32'd0, 0, 32'd0);
        issue("load_ack3", OP_LOAD, 9'd5, 7'd2, 32'h40, 32'd0, 3, 32'hDEAD);
        idle_cycle("hold_after_load");
        issue("store_ack1", OP_STORE, 9'd6, 7'd3, 32'h10, 32'd9, 1, 32'h1234);
        issue("load_timeout", OP_LOAD, 9'd12, 7'd4, 32'h80, 32'd0, TIMEOUT + 5, 32'd0);
        idle_cycle("hold_after_timeout");
        issue("load_ack_last", OP_LOAD, 9'd13, 7'd5, 32'h84, 32'd0, TIMEOUT, 32'hBEEF);
        issue("nop", OP_NOP, 9'd1, 7'd6, 32'h55, 32'd0, 0, 32'd0);
        issue("alu_b2b", 5'd20, 9'd300, 7'd127, 32'hFFFF_FFFF, 32'd0, 0, 32'd0);

        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 4));
            case (kind)
                0:       op = OP_LOAD;
                1:       op = OP_STORE;
                2:       op = OP_NOP;
                default: begin
                    op = 5'($urandom_range(1, 29));
                    if (op >= 5'd14) op = op + 5'd2;
                end
            endcase
            issue("rand", op, RD_W'($urandom), BR_W'($urandom), $urandom, $urandom,
                  int'($urandom_range(1, TIMEOUT + 2)), $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycle("rand_idle");
        end

        // Reset during an outstanding load
        in_valid = 1'b1; OpCode = OP_LOAD; RdOut = 9'd9; BranchResult = 7'd0;
        AluResult = 32'h200; store_data = 32'd0;
        @(posedge clk); #1;
        in_valid = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        check("rst_pre_mem_req", 64'(mem_req), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mid");
        issue("alu_after_rst", 5'd11, 9'd7, 7'd3, 32'h1234_5678, 32'd0, 0, 32'd0);
        idle_cycle("final_idle");

        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
